// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if
//   Bundles the writeback request, the long-latency valid/ready handshake and
//   the register-file write port of rf_write_arbiter.
//   master : driven by the datapath side (WB stage, long-latency unit),
//            observes lu_ready, stall and the register-file write port.
//   slave  : the arbiter itself.
//   Parameter DATA_W sets the width of all data fields.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              wb_valid;
    logic [4:0]        wb_rt;
    logic [4:0]        wb_rd;
    logic [1:0]        wb_regdst;
    logic [DATA_W-1:0] wb_data;
    logic              lu_valid;
    logic              lu_ready;
    logic [4:0]        lu_dst;
    logic [DATA_W-1:0] lu_data;
    logic              stall;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output wb_valid, wb_rt, wb_rd, wb_regdst, wb_data,
        output lu_valid, lu_dst, lu_data,
        input  lu_ready, stall, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_rt, wb_rd, wb_regdst, wb_data,
        input  lu_valid, lu_dst, lu_data,
        output lu_ready, stall, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between the in-order WB stage
//   and a long-latency unit (mult/div). Long-latency results are buffered in a
//   small FIFO; WB normally wins, but after STARVE_MAX consecutive cycles of the
//   FIFO being passed over, the FIFO head is forced onto the port and the
//   pipeline is stalled for one cycle.
//
//   Ports:
//     Clk      - clock, rising edge
//     Reset_n  - asynchronous active-low reset
//     bus      - rf_write_arbiter_if.slave: WB request (wb_*), long-latency
//                handshake (lu_valid/lu_ready/lu_dst/lu_data), stall, and the
//                registered register-file write port (rf_we/rf_waddr/rf_wdata)
//
//   Parameters: DATA_W, FIFO_DEPTH (power of two, >=2), STARVE_MAX (>=1)
//
//   Build option: define RFWA_ZERO_FILTER_EN to suppress rf_we for granted
//   writes to register 0 (the grant is still consumed).
module rf_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                Clk,
    input  logic                Reset_n,
    rf_write_arbiter_if.slave   bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ST_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [ST_W-1:0]  STARVE_C = ST_W'(STARVE_MAX);

    logic [4:0]        fifo_dst  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ST_W-1:0]   starve_cnt;

    logic              fifo_ne;
    logic              starve_hit;
    logic              grant_fifo;
    logic              grant_wb;
    logic              push;
    logic              sel_we;
    logic [4:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;

    // 0 -> rt, 1 -> rd, 2/3 -> link register (JAL)
    function automatic logic [4:0] wb_dest(input logic [1:0] regdst,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
        case (regdst)
            2'd0:    return rt;
            2'd1:    return rd;
            default: return 5'd31;
        endcase
    endfunction

    assign fifo_ne    = (count != '0);
    assign starve_hit = (starve_cnt == STARVE_C);

    // Ready depends only on registered occupancy: a full FIFO refuses a push
    // even in the cycle it pops, which keeps lu_ready off the grant path.
    assign bus.lu_ready = Reset_n && (count < DEPTH_C);
    assign push         = bus.lu_valid && bus.lu_ready;

    assign grant_fifo = fifo_ne && (!bus.wb_valid || starve_hit);
    assign grant_wb   = !grant_fifo && bus.wb_valid;
    assign bus.stall  = Reset_n && bus.wb_valid && fifo_ne && starve_hit;

    always_comb begin
        sel_addr = wb_dest(bus.wb_regdst, bus.wb_rt, bus.wb_rd);
        sel_data = bus.wb_data;
        if (grant_fifo) begin
            sel_addr = fifo_dst[rd_ptr];
            sel_data = fifo_data[rd_ptr];
        end
`ifdef RFWA_ZERO_FILTER_EN
        sel_we = (grant_fifo || grant_wb) && (sel_addr != 5'd0);
`else
        sel_we = grant_fifo || grant_wb;
`endif
    end

    // FIFO storage: contents are meaningless until count covers them, so no reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_dst[wr_ptr]  <= bus.lu_dst;
            fifo_data[wr_ptr] <= bus.lu_data;
        end
    end

    // Control state and registered write port
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            starve_cnt   <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            bus.rf_we    <= sel_we;
            bus.rf_waddr <= sel_addr;
            bus.rf_wdata <= sel_data;

            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (grant_fifo)
                rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, grant_fifo})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Counts WB wins while the FIFO waits; any FIFO grant or an empty
            // FIFO means nobody is being starved.
            if (!fifo_ne || grant_fifo)
                starve_cnt <= '0;
            else if (grant_wb && !starve_hit)
                starve_cnt <= starve_cnt + ST_W'(1);
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
    logic Clk;
    logic Reset_n;
    int   vectors;
    int   miscompares;

    rf_write_arbiter_if #(.DATA_W(32)) bus ();

    rf_write_arbiter #(
        .DATA_W    (32),
        .FIFO_DEPTH(2),
        .STARVE_MAX(4)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        wbv;
        logic [1:0]  regdst;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] wbdata;
        logic        luv;
        logic [4:0]  ludst;
        logic [31:0] ludata;
        logic        e_stall;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } row_t;

    row_t rows[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic row_t mk(input logic wbv, input logic [1:0] regdst,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [31:0] wbdata, input logic luv,
                                input logic [4:0] ludst, input logic [31:0] ludata,
                                input logic e_stall, input logic e_ready,
                                input logic e_we, input logic [4:0] e_waddr,
                                input logic [31:0] e_wdata);
        row_t r;
        r.wbv = wbv; r.regdst = regdst; r.rt = rt; r.rd = rd; r.wbdata = wbdata;
        r.luv = luv; r.ludst = ludst; r.ludata = ludata;
        r.e_stall = e_stall; r.e_ready = e_ready; r.e_we = e_we;
        r.e_waddr = e_waddr; r.e_wdata = e_wdata;
        return r;
    endfunction

    // Shorthand: WB uses rd (regdst=1) with data 0x1000+rd, LU data is 0x2000+dst
    function automatic row_t mkw(input logic wbv, input logic [4:0] rd,
                                 input logic luv, input logic [4:0] ludst,
                                 input logic e_stall, input logic e_ready,
                                 input logic e_we, input logic [4:0] e_waddr,
                                 input logic [31:0] e_wdata);
        return mk(wbv, 2'd1, 5'd0, rd, 32'h1000 + 32'(rd), luv, ludst,
                  32'h2000 + 32'(ludst), e_stall, e_ready, e_we, e_waddr, e_wdata);
    endfunction

    // Entered just after a rising edge; leaves just after the next one.
    task automatic run_row(input int idx, input row_t r);
        bus.wb_valid  = r.wbv;
        bus.wb_regdst = r.regdst;
        bus.wb_rt     = r.rt;
        bus.wb_rd     = r.rd;
        bus.wb_data   = r.wbdata;
        bus.lu_valid  = r.luv;
        bus.lu_dst    = r.ludst;
        bus.lu_data   = r.ludata;
        #1;
        check($sformatf("row%0d stall", idx), 64'(bus.stall), 64'(r.e_stall));
        check($sformatf("row%0d lu_ready", idx), 64'(bus.lu_ready), 64'(r.e_ready));
        @(posedge Clk);
        #1;
        check($sformatf("row%0d rf_we", idx), 64'(bus.rf_we), 64'(r.e_we));
        if (r.e_we || r.wbv) begin
            check($sformatf("row%0d rf_waddr", idx), 64'(bus.rf_waddr), 64'(r.e_waddr));
            check($sformatf("row%0d rf_wdata", idx), 64'(bus.rf_wdata), 64'(r.e_wdata));
        end
    endtask

    logic zf_we;

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset_n     = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_regdst = 2'd0;
        bus.wb_rt     = 5'd0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 32'd0;
        bus.lu_valid  = 1'b0;
        bus.lu_dst    = 5'd0;
        bus.lu_data   = 32'd0;

`ifdef RFWA_ZERO_FILTER_EN
        zf_we = 1'b0;
`else
        zf_we = 1'b1;
`endif

        // Reset state
        #2;
        check("rst rf_we", 64'(bus.rf_we), 64'd0);
        check("rst rf_waddr", 64'(bus.rf_waddr), 64'd0);
        check("rst rf_wdata", 64'(bus.rf_wdata), 64'd0);
        check("rst lu_ready", 64'(bus.lu_ready), 64'd0);
        check("rst stall", 64'(bus.stall), 64'd0);
        #10 Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // WB destination decode
        rows.push_back(mk(1, 2'd0, 5'd8, 5'd9, 32'h1234, 0, 0, 0, 0, 1, 1, 5'd8,  32'h1234));
        rows.push_back(mk(1, 2'd1, 5'd8, 5'd9, 32'h1234, 0, 0, 0, 0, 1, 1, 5'd9,  32'h1234));
        rows.push_back(mk(1, 2'd2, 5'd8, 5'd9, 32'h1234, 0, 0, 0, 0, 1, 1, 5'd31, 32'h1234));
        rows.push_back(mk(1, 2'd3, 5'd8, 5'd9, 32'h5678, 0, 0, 0, 0, 1, 1, 5'd31, 32'h5678));
        // Write to register 0
        rows.push_back(mk(1, 2'd1, 5'd8, 5'd0, 32'hFFFF, 0, 0, 0, 0, 1, zf_we, 5'd0, 32'hFFFF));
        rows.push_back(mk(0, 2'd0, 5'd0, 5'd0, 32'h0, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0));
        // LU path: pushed at edge N, written after edge N+1
        rows.push_back(mk(0, 2'd0, 5'd0, 5'd0, 32'h0, 1, 5'd5, 32'hABCD, 0, 1, 0, 5'd0, 32'h0));
        rows.push_back(mk(0, 2'd0, 5'd0, 5'd0, 32'h0, 0, 0, 0, 0, 1, 1, 5'd5, 32'hABCD));
        rows.push_back(mk(0, 2'd0, 5'd0, 5'd0, 32'h0, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0));
        // Starvation: entry for r6 waits behind four WB writes, then forced
        rows.push_back(mkw(1, 5'd10, 1, 5'd6, 0, 1, 1, 5'd10, 32'h100A));
        rows.push_back(mkw(1, 5'd11, 0, 5'd0, 0, 1, 1, 5'd11, 32'h100B));
        rows.push_back(mkw(1, 5'd12, 0, 5'd0, 0, 1, 1, 5'd12, 32'h100C));
        rows.push_back(mkw(1, 5'd13, 0, 5'd0, 0, 1, 1, 5'd13, 32'h100D));
        rows.push_back(mkw(1, 5'd14, 0, 5'd0, 0, 1, 1, 5'd14, 32'h100E));
        rows.push_back(mkw(1, 5'd15, 0, 5'd0, 1, 1, 1, 5'd6,  32'h2006));
        rows.push_back(mkw(1, 5'd15, 0, 5'd0, 0, 1, 1, 5'd15, 32'h100F));
        rows.push_back(mkw(0, 5'd0,  0, 5'd0, 0, 1, 0, 5'd0,  32'h0));
        // Full FIFO under continuous WB traffic
        rows.push_back(mkw(1, 5'd1, 1, 5'd20, 0, 1, 1, 5'd1,  32'h1001));
        rows.push_back(mkw(1, 5'd2, 1, 5'd21, 0, 1, 1, 5'd2,  32'h1002));
        rows.push_back(mkw(1, 5'd3, 1, 5'd22, 0, 0, 1, 5'd3,  32'h1003));
        rows.push_back(mkw(1, 5'd4, 1, 5'd22, 0, 0, 1, 5'd4,  32'h1004));
        rows.push_back(mkw(1, 5'd5, 1, 5'd22, 0, 0, 1, 5'd5,  32'h1005));
        rows.push_back(mkw(1, 5'd6, 1, 5'd22, 1, 0, 1, 5'd20, 32'h2014));
        rows.push_back(mkw(1, 5'd6, 1, 5'd22, 0, 1, 1, 5'd6,  32'h1006));
        rows.push_back(mkw(0, 5'd0, 0, 5'd0,  0, 0, 1, 5'd21, 32'h2015));
        rows.push_back(mkw(0, 5'd0, 0, 5'd0,  0, 1, 1, 5'd22, 32'h2016));
        rows.push_back(mkw(0, 5'd0, 0, 5'd0,  0, 1, 0, 5'd0,  32'h0));
        // Leave one entry (dst 7) in the FIFO for the reset check
        rows.push_back(mkw(1, 5'd3, 1, 5'd7,  0, 1, 1, 5'd3,  32'h1003));

        foreach (rows[i]) run_row(i, rows[i]);

        // Mid-traffic reset with one buffered entry and WB still requesting
        bus.lu_valid = 1'b0;
        #1 Reset_n = 1'b0;
        #1;
        check("midrst rf_we", 64'(bus.rf_we), 64'd0);
        check("midrst rf_waddr", 64'(bus.rf_waddr), 64'd0);
        check("midrst rf_wdata", 64'(bus.rf_wdata), 64'd0);
        check("midrst lu_ready", 64'(bus.lu_ready), 64'd0);
        check("midrst stall", 64'(bus.stall), 64'd0);
        bus.wb_valid = 1'b0;
        @(posedge Clk);
        #2 Reset_n = 1'b1;
        #1;
        check("postrst lu_ready", 64'(bus.lu_ready), 64'd1);
        check("postrst stall", 64'(bus.stall), 64'd0);
        @(posedge Clk);
        #1;
        check("postrst rf_we 1", 64'(bus.rf_we), 64'd0);
        @(posedge Clk);
        #1;
        check("postrst rf_we 2", 64'(bus.rf_we), 64'd0);
        check("postrst lu_ready 2", 64'(bus.lu_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
